buzzer_scheduler: RTL and testbench

Shares the single FPGA Buzzer pin among four vending-machine alarm sources (e.g. invalid coin, out of stock, insufficient credit, change empty). Each source raises a request; the block latches it, arbitrates by fixed priority and plays a source-specific beep pattern: source i emits i+1 beeps, then a silent gap. It runs on the 1-second tick and replaces direct single-source Buzzer control.

---
 rtl/buzzer_scheduler_if.sv | 22 ++
 rtl/buzzer_scheduler.sv | 141 ++++++++++++++
 tb/tb_buzzer_scheduler.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/buzzer_scheduler_if.sv
// Alarm-side bundle of the buzzer scheduler: requests and controls in, pin and status out.
// The master modport is the alarm logic, the slave modport is the scheduler.
interface buzzer_scheduler_if;
   logic [3:0] req;
   logic       cancel;
   logic       mute;
   logic       Buzzer;
   logic       busy;
   logic [1:0] active_id;
   logic [3:0] pending;
   logic       done;

   modport master (
      output req, cancel, mute,
      input  Buzzer, busy, active_id, pending, done
   );

   modport slave (
      input  req, cancel, mute,
      output Buzzer, busy, active_id, pending, done
   );
endinterface

// File: rtl/buzzer_scheduler.sv
// Shares one buzzer pin among four latched alarm sources; the granted source i
// plays i+1 beeps followed by a silent gap, lowest index first, no preemption.
module buzzer_scheduler #(
   parameter int ON_TICKS  = 1,
   parameter int OFF_TICKS = 1,
   parameter int GAP_TICKS = 2
) (
   input  logic              clk_1_second,
   input  logic              reset,
   buzzer_scheduler_if.slave bus
);
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ON   = 2'd1;
   localparam logic [1:0] ST_OFF  = 2'd2;
   localparam logic [1:0] ST_GAP  = 2'd3;

   localparam logic [3:0] ON_LAST  = 4'(ON_TICKS - 1);
   localparam logic [3:0] OFF_LAST = 4'(OFF_TICKS - 1);
   localparam logic [3:0] GAP_LAST = 4'(GAP_TICKS - 1);

   logic [1:0] state_q, state_d;
   logic [3:0] tick_q, tick_d;
   logic [2:0] beeps_q, beeps_d;
   logic       buzz_q, buzz_d;
   logic       done_q, done_d;
   logic [1:0] active_id_q, active_id_d;
   logic [3:0] pending_q, pending_d;

   logic [1:0] grant_idx;
   logic [3:0] grant_mask;

   // Lowest set index wins; scanning downward lets the last hit be the lowest.
   always_comb begin
      grant_idx = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (pending_q[i]) grant_idx = 2'(i);
      end
   end

   always_comb begin
      state_d     = state_q;
      tick_d      = tick_q;
      beeps_d     = beeps_q;
      buzz_d      = buzz_q;
      done_d      = 1'b0;
      active_id_d = active_id_q;
      grant_mask  = 4'b0000;

      case (state_q)
         ST_IDLE: begin
            if (|pending_q) begin
               grant_mask  = 4'b0001 << grant_idx;
               active_id_d = grant_idx;
               beeps_d     = {1'b0, grant_idx} + 3'd1;
               buzz_d      = 1'b1;
               tick_d      = 4'd0;
               state_d     = ST_ON;
            end
         end
         ST_ON: begin
            if (tick_q == ON_LAST) begin
               tick_d = 4'd0;
               buzz_d = 1'b0;
               if (beeps_q == 3'd1) begin
                  done_d  = 1'b1;
                  state_d = ST_GAP;
               end else begin
                  beeps_d = beeps_q - 3'd1;
                  state_d = ST_OFF;
               end
            end else begin
               tick_d = tick_q + 4'd1;
            end
         end
         ST_OFF: begin
            if (tick_q == OFF_LAST) begin
               tick_d  = 4'd0;
               buzz_d  = 1'b1;
               state_d = ST_ON;
            end else begin
               tick_d = tick_q + 4'd1;
            end
         end
         ST_GAP: begin
            if (tick_q == GAP_LAST) begin
               tick_d  = 4'd0;
               state_d = ST_IDLE;
            end else begin
               tick_d = tick_q + 4'd1;
            end
         end
         default: begin
            tick_d  = 4'd0;
            buzz_d  = 1'b0;
            state_d = ST_IDLE;
         end
      endcase

      // A request on the grant edge re-queues the granted bit (set wins over clear).
      pending_d = (pending_q & ~grant_mask) | bus.req;

      // Cancel drops everything, including requests sampled on this edge,
      // but keeps the most recent grant visible on active_id.
      if (bus.cancel) begin
         pending_d   = 4'b0000;
         buzz_d      = 1'b0;
         done_d      = 1'b0;
         tick_d      = 4'd0;
         beeps_d     = 3'd0;
         state_d     = ST_IDLE;
         active_id_d = active_id_q;
      end
   end

   always_ff @(posedge clk_1_second) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         tick_q      <= 4'd0;
         beeps_q     <= 3'd0;
         buzz_q      <= 1'b0;
         done_q      <= 1'b0;
         active_id_q <= 2'd0;
         pending_q   <= 4'b0000;
      end else begin
         state_q     <= state_d;
         tick_q      <= tick_d;
         beeps_q     <= beeps_d;
         buzz_q      <= buzz_d;
         done_q      <= done_d;
         active_id_q <= active_id_d;
         pending_q   <= pending_d;
      end
   end

   // Mute gates the pin only, so sequencing and status are unaffected by it.
   assign bus.Buzzer    = buzz_q & ~bus.mute;
   assign bus.busy      = (state_q != ST_IDLE);
   assign bus.active_id = active_id_q;
   assign bus.pending   = pending_q;
   assign bus.done      = done_q;
endmodule

// File: tb/tb_buzzer_scheduler.sv
// Self-checking bench: directed scenarios plus random traffic, every edge compared
// against a schedule model built from alarm start edges and beep arithmetic.
module tb_buzzer_scheduler;
   localparam int ON_T  = 1;
   localparam int OFF_T = 1;
   localparam int GAP_T = 2;

   logic clk_1_second = 1'b0;
   logic reset        = 1'b1;

   buzzer_scheduler_if bus_if ();

   buzzer_scheduler #(
      .ON_TICKS  (ON_T),
      .OFF_TICKS (OFF_T),
      .GAP_TICKS (GAP_T)
   ) dut (
      .clk_1_second (clk_1_second),
      .reset        (reset),
      .bus          (bus_if.slave)
   );

   always #5 clk_1_second = ~clk_1_second;

   int vectors     = 0;
   int miscompares = 0;
   int edge_no     = 0;

   // Reference model: pending set, and the currently playing alarm described
   // only by its source and the edge it was granted on.
   logic [3:0] m_pending   = 4'b0000;
   bit         m_active    = 1'b0;
   int         m_id        = 0;
   int         m_g         = 0;
   logic [1:0] m_active_id = 2'd0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s at edge %0d: got %0h, expected %0h", tag, edge_no, got, exp);
      end
   endtask

   function automatic int alarm_span(input int id);
      return id * (ON_T + OFF_T) + ON_T + GAP_T;
   endfunction

   task automatic model_edge(input logic r, input logic [3:0] rq, input logic c);
      logic [3:0] mask;
      mask = 4'b0000;
      if (r) begin
         m_pending   = 4'b0000;
         m_active    = 1'b0;
         m_active_id = 2'd0;
      end else if (c) begin
         m_pending = 4'b0000;
         m_active  = 1'b0;
      end else begin
         if (m_active) begin
            if (edge_no - m_g == alarm_span(m_id)) m_active = 1'b0;
         end else if (m_pending != 4'b0000) begin
            for (int i = 3; i >= 0; i--) begin
               if (m_pending[i]) m_id = i;
            end
            mask        = 4'b0001 << m_id;
            m_g         = edge_no;
            m_active    = 1'b1;
            m_active_id = 2'(m_id);
            $display("edge %0d: grant source %0d (%0d beeps)", edge_no, m_id, m_id + 1);
         end
         m_pending = (m_pending & ~mask) | rq;
      end
   endtask

   task automatic step(input logic r, input logic [3:0] rq, input logic c, input logic m);
      int   period;
      int   last_end;
      int   o;
      logic exp_buzz;
      logic exp_done;
      reset         = r;
      bus_if.req    = rq;
      bus_if.cancel = c;
      bus_if.mute   = m;
      @(posedge clk_1_second);
      edge_no++;
      model_edge(r, rq, c);
      #1;
      period   = ON_T + OFF_T;
      last_end = m_id * period + ON_T;
      o        = edge_no - m_g;
      exp_buzz = m_active && (o < last_end) && ((o % period) < ON_T);
      exp_done = m_active && (o == last_end);
      if (exp_done) $display("edge %0d: done source %0d", edge_no, m_id);
      chk("Buzzer",    32'(bus_if.Buzzer),    32'(exp_buzz & ~m));
      chk("busy",      32'(bus_if.busy),      32'(m_active));
      chk("active_id", 32'(bus_if.active_id), 32'(m_active_id));
      chk("pending",   32'(bus_if.pending),   32'(m_pending));
      chk("done",      32'(bus_if.done),      32'(exp_done));
   endtask

   task automatic idle(input int n, input logic m);
      for (int i = 0; i < n; i++) step(1'b0, 4'b0000, 1'b0, m);
   endtask

   initial begin
      bus_if.req    = 4'b0000;
      bus_if.cancel = 1'b0;
      bus_if.mute   = 1'b0;

      // Reset values.
      step(1'b1, 4'b0000, 1'b0, 1'b0);
      step(1'b1, 4'b0000, 1'b0, 1'b0);

      // Single 2-beep alarm from source 1.
      step(1'b0, 4'b0010, 1'b0, 1'b0);
      idle(10, 1'b0);

      // Simultaneous sources 0 and 3.
      step(1'b0, 4'b1001, 1'b0, 1'b0);
      idle(20, 1'b0);

      // Source 2 held high: back-to-back alarms.
      for (int i = 0; i < 30; i++) step(1'b0, 4'b0100, 1'b0, 1'b0);
      idle(10, 1'b0);

      // Cancel during OFF of a 3-beep alarm with source 0 pending.
      step(1'b0, 4'b0100, 1'b0, 1'b0);
      step(1'b0, 4'b0000, 1'b0, 1'b0);
      step(1'b0, 4'b0001, 1'b0, 1'b0);
      step(1'b0, 4'b0000, 1'b1, 1'b0);
      idle(6, 1'b0);

      // Muted 2-beep alarm.
      step(1'b0, 4'b0010, 1'b0, 1'b1);
      idle(10, 1'b1);

      // Reset mid-ON with a request pending.
      step(1'b0, 4'b1000, 1'b0, 1'b0);
      step(1'b0, 4'b0000, 1'b0, 1'b0);
      step(1'b0, 4'b0001, 1'b0, 1'b0);
      step(1'b0, 4'b0000, 1'b0, 1'b0);
      step(1'b1, 4'b0000, 1'b0, 1'b0);
      idle(4, 1'b0);

      // Random traffic.
      for (int i = 0; i < 1500; i++) begin
         logic [3:0] rq;
         logic       c;
         logic       r;
         logic       m;
         rq = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0000;
         c  = ($urandom_range(0, 59) == 0);
         r  = ($urandom_range(0, 299) == 0);
         m  = ($urandom_range(0, 3) == 0);
         step(r, rq, c, m);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
